// File: rtl/uart_tx_feeder_pkg.sv
// uart_tx_feeder_pkg: FSM encodings and frame constants shared by the UART transmit path
package uart_tx_feeder_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        ARM    = 3'd2,
        BUSY   = 3'd3,
        GAP    = 3'd4
    } tx_state_t;

    localparam int STOP_TICKS_DEF = 16;
    localparam int TICKS_PER_BIT  = 16;
    localparam int FRAME_BITS     = 10;
    localparam int FRAME_TICKS    = FRAME_BITS * TICKS_PER_BIT;

endpackage

// File: rtl/uart_tx_feeder_sync_fifo.sv
// sync_fifo: single-clock byte FIFO with level tracking and drop-on-full, shared by TX and RX paths
module sync_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int WIDTH  = 8
) (
    input  logic              br_clk_16,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    output logic [WIDTH-1:0]  rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              drop
);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              wr_ok;
    logic              rd_ok;

    assign full    = level == (ADDR_W+1)'(DEPTH);
    assign empty   = level == '0;
    assign drop    = wr_en && full;
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // storage is deliberately left unreset; only accepted writes land
    always_ff @(posedge br_clk_16) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge br_clk_16 or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (rd_ok) rd_ptr <= rd_ptr + ADDR_W'(1);
            level <= level + (ADDR_W+1)'(wr_ok) - (ADDR_W+1)'(rd_ok);
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: buffers CPU bytes and launches them into the UART sender with a stop-bit gap
module uart_tx_feeder
    import uart_tx_feeder_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4,
    parameter int STOP_TICKS = STOP_TICKS_DEF
) (
    input  logic            br_clk_16,
    input  logic            reset,
    input  logic            wr_en,
    input  logic [7:0]      wr_data,
    input  logic            ovf_clr,
    input  logic            TX_STATUS,
    output logic [7:0]      TX_DATA,
    output logic            TX_EN,
    output logic            full,
    output logic            empty,
    output logic [ADDR_W:0] level,
    output logic            overflow
);

    localparam int GAP_W = $clog2(STOP_TICKS + 1);

    tx_state_t        state;
    tx_state_t        state_n;
    logic [GAP_W-1:0] gap_cnt;
    logic [GAP_W-1:0] gap_n;
    logic [7:0]       tx_data_n;
    logic [7:0]       rd_data;
    logic             tx_en_n;
    logic             pop;
    logic             drop;

    sync_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WIDTH  (8)
    ) u_fifo (
        .br_clk_16 (br_clk_16),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .rd_en     (pop),
        .rd_data   (rd_data),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .drop      (drop)
    );

    // launch sequencing: TX_EN is only ever produced on the IDLE->LAUNCH edge, so it cannot repeat
    always_comb begin
        state_n   = state;
        gap_n     = gap_cnt;
        tx_data_n = TX_DATA;
        tx_en_n   = 1'b0;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && TX_STATUS) begin
                    state_n   = LAUNCH;
                    tx_en_n   = 1'b1;
                    tx_data_n = rd_data;
                end
            end
            LAUNCH: begin
                state_n = ARM;
                pop     = 1'b1;
            end
            ARM: state_n = BUSY;
            BUSY: begin
                if (TX_STATUS) begin
                    state_n = GAP;
                    gap_n   = '0;
                end
            end
            GAP: begin
                gap_n = gap_cnt + GAP_W'(1);
                if (gap_cnt == GAP_W'(STOP_TICKS - 1)) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // state, gap counter and the registered sender interface
    always_ff @(posedge br_clk_16 or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            gap_cnt <= '0;
            TX_EN   <= 1'b0;
            TX_DATA <= '0;
        end else begin
            state   <= state_n;
            gap_cnt <= gap_n;
            TX_EN   <= tx_en_n;
            TX_DATA <= tx_data_n;
        end
    end

    // sticky overflow; a drop in the same cycle as a clear keeps the flag set
    always_ff @(posedge br_clk_16 or negedge reset) begin
        if (!reset) overflow <= 1'b0;
        else if (drop) overflow <= 1'b1;
        else if (ovf_clr) overflow <= 1'b0;
    end

endmodule
